// File: rtl/ysyx_23060221_ifu.sv
// ysyx_23060221_ifu: instruction fetch unit for the multi-cycle core.
//
// Accepts the next PC from writeback (wbu_valid/ifu_ready). It fetches that
// word over an AXI-lite style read channel (ar*/r*). It then hands the
// instruction, its PC and an error flag to decode (ifu_valid/idu_ready).
// The first fetch after reset goes to RESET_PC without waiting for
// writeback. A misaligned PC never reaches memory. It is reported straight
// away as a faulted fetch.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   wbu_valid, pc_in         next PC offered by writeback
//   ifu_ready                high only while waiting for the next PC
//   mem_araddr, mem_arvalid  read address channel (driven)
//   mem_arready              read address accepted by memory
//   mem_rdata, mem_rresp     read data / response (2'b00 = OKAY)
//   mem_rvalid, mem_rready   read data handshake
//   inst, inst_pc, fetch_err fetched word, its PC and fault flag
//   ifu_valid, idu_ready     handshake towards decode
module ysyx_23060221_ifu #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbu_valid,
    output logic              ifu_ready,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              ifu_valid,
    input  logic              idu_ready,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        BOOT,
        AR,
        R,
        OUT,
        IDLE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Each state's outgoing handshake signal is high for the whole state.
    // That makes the raw input alone enough to decide every transition.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = AR;
            AR:      if (mem_arready) state_next = R;
            R:       if (mem_rvalid) state_next = OUT;
            OUT:     if (idu_ready) state_next = IDLE;
            IDLE: begin
                if (wbu_valid) begin
                    state_next = (pc_in[1:0] == 2'b00) ? AR : OUT;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // The handshake outputs are registered copies of the next-state decode.
    // Each one is therefore high exactly while the FSM sits in its state.
    // arvalid (AR) and rready (R) can never be high together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_ready   <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            ifu_valid   <= 1'b0;
            fetch_err   <= 1'b0;
            pc_reg      <= RESET_PC;
            mem_araddr  <= RESET_PC;
            inst_pc     <= RESET_PC;
            inst        <= '0;
        end else begin
            ifu_ready   <= (state_next == IDLE);
            mem_arvalid <= (state_next == AR);
            mem_rready  <= (state_next == R);
            ifu_valid   <= (state_next == OUT);
            case (state)
                R: begin
                    if (mem_rvalid) begin
                        inst      <= mem_rdata;
                        inst_pc   <= pc_reg;
                        fetch_err <= (mem_rresp != 2'b00);
                    end
                end
                OUT: begin
                    if (idu_ready) begin
                        fetch_err <= 1'b0;
                    end
                end
                IDLE: begin
                    if (wbu_valid) begin
                        pc_reg     <= pc_in;
                        mem_araddr <= pc_in;
                        // A misaligned PC skips memory and is reported as a
                        // faulted fetch with an all-zero instruction.
                        if (pc_in[1:0] != 2'b00) begin
                            inst      <= '0;
                            inst_pc   <= pc_in;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
